// File: rtl/simple_bus_monitor.sv
// Passive bus monitor: reconstructs start/address/data transactions from the
// bus control lines, reports completed transactions and protocol errors, and
// keeps running transaction and error counts.
module simple_bus_monitor #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        resetN,
    input  logic        enable,
    input  logic        clrCounts,
    input  logic        start,
    input  logic        read,
    input  logic        dataValid,
    input  logic [7:0]  address,
    input  logic [7:0]  data,
    output logic        txnValid,
    output logic        txnRead,
    output logic [15:0] txnAddr,
    output logic [7:0]  txnData,
    output logic [7:0]  txnWait,
    output logic        errValid,
    output logic [1:0]  errCode,
    output logic [15:0] txnCount,
    output logic [7:0]  errCount
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADDR_LO = 2'd1,
        RD_WAIT = 2'd2,
        WR_WAIT = 2'd3
    } stateT;

    localparam logic [1:0] ERR_SPURIOUS = 2'b01;
    localparam logic [1:0] ERR_START    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    // Last wait count before a timeout fires (counter starts at 0).
    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    stateT      state, stateNext;
    logic [7:0] waitCnt, waitNext;
    logic [7:0] addrHi, addrHiNext;
    logic [7:0] addrLo, addrLoNext;
    logic       readLat, readNext;
    logic       txnFire;
    logic       errFire;
    logic [1:0] errCodeNext;

    // FSM state and transaction context register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            waitCnt <= '0;
            addrHi  <= '0;
            addrLo  <= '0;
            readLat <= 1'b0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
            addrHi  <= addrHiNext;
            addrLo  <= addrLoNext;
            readLat <= readNext;
        end
    end

    // Next-state decode and event detection; start-error outranks spurious data.
    always_comb begin
        stateNext   = state;
        waitNext    = waitCnt;
        addrHiNext  = addrHi;
        addrLoNext  = addrLo;
        readNext    = readLat;
        txnFire     = 1'b0;
        errFire     = 1'b0;
        errCodeNext = ERR_SPURIOUS;

        if (!enable) begin
            stateNext = IDLE;
            waitNext  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        addrHiNext = address;
                        stateNext  = ADDR_LO;
                    end else if (dataValid) begin
                        errFire     = 1'b1;
                        errCodeNext = ERR_SPURIOUS;
                    end
                end
                ADDR_LO: begin
                    if (start) begin
                        errFire     = 1'b1;
                        errCodeNext = ERR_START;
                        addrHiNext  = address;
                    end else begin
                        addrLoNext = address;
                        readNext   = read;
                        waitNext   = '0;
                        stateNext  = read ? RD_WAIT : WR_WAIT;
                        if (dataValid) begin
                            errFire     = 1'b1;
                            errCodeNext = ERR_SPURIOUS;
                        end
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    if (dataValid) begin
                        // Completion may overlap the next transaction's start.
                        txnFire   = 1'b1;
                        stateNext = IDLE;
                        if (start) begin
                            addrHiNext = address;
                            stateNext  = ADDR_LO;
                        end
                    end else if (start) begin
                        errFire     = 1'b1;
                        errCodeNext = ERR_START;
                        addrHiNext  = address;
                        stateNext   = ADDR_LO;
                    end else if (waitCnt == WAIT_LIMIT) begin
                        errFire     = 1'b1;
                        errCodeNext = ERR_TIMEOUT;
                        stateNext   = IDLE;
                    end else begin
                        waitNext = waitCnt + 8'd1;
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    // Registered reporting outputs and counters; clear beats increment.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            txnValid <= 1'b0;
            txnRead  <= 1'b0;
            txnAddr  <= '0;
            txnData  <= '0;
            txnWait  <= '0;
            errValid <= 1'b0;
            errCode  <= '0;
            txnCount <= '0;
            errCount <= '0;
        end else begin
            txnValid <= txnFire;
            errValid <= errFire;
            if (txnFire) begin
                txnRead <= readLat;
                txnAddr <= {addrHi, addrLo};
                txnData <= data;
                // Counter never passes TIMEOUT-1 (<= 254), so it is already saturated.
                txnWait <= waitCnt;
            end
            if (errFire) begin
                errCode <= errCodeNext;
            end
            if (clrCounts) begin
                txnCount <= '0;
            end else if (txnFire) begin
                txnCount <= txnCount + 16'd1;
            end
            if (clrCounts) begin
                errCount <= '0;
            end else if (errFire && errCount != 8'hFF) begin
                errCount <= errCount + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_simple_bus_monitor.sv
// Self-checking bench for simple_bus_monitor: a transaction-level model is
// compared against the DUT every cycle, plus literal spot checks.
module tb_simple_bus_monitor;

    localparam int TMO = 16;

    logic        clock;
    logic        resetN;
    logic        enable;
    logic        clrCounts;
    logic        start;
    logic        read;
    logic        dataValid;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        txnValid;
    logic        txnRead;
    logic [15:0] txnAddr;
    logic [7:0]  txnData;
    logic [7:0]  txnWait;
    logic        errValid;
    logic [1:0]  errCode;
    logic [15:0] txnCount;
    logic [7:0]  errCount;

    int nChecks = 0;
    int nPass   = 0;

    simple_bus_monitor #(.TIMEOUT(TMO)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .enable    (enable),
        .clrCounts (clrCounts),
        .start     (start),
        .read      (read),
        .dataValid (dataValid),
        .address   (address),
        .data      (data),
        .txnValid  (txnValid),
        .txnRead   (txnRead),
        .txnAddr   (txnAddr),
        .txnData   (txnData),
        .txnWait   (txnWait),
        .errValid  (errValid),
        .errCode   (errCode),
        .txnCount  (txnCount),
        .errCount  (errCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Transaction-level model: phase 0 = no transaction, 1 = awaiting low
    // address byte, 2 = awaiting data.
    int          phase;
    bit          mRead;
    logic [15:0] mAddr;
    int          mWaits;
    int          errKind;
    logic        eTxnValid, eTxnRead, eErrValid;
    logic [15:0] eTxnAddr, eTxnCount;
    logic [7:0]  eTxnData, eTxnWait;
    logic [1:0]  eErrCode;
    int          eErrCount;

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            phase = 0; mRead = 0; mAddr = 0; mWaits = 0;
            eTxnValid = 0; eTxnRead = 0; eTxnAddr = 0; eTxnData = 0; eTxnWait = 0;
            eErrValid = 0; eErrCode = 0; eTxnCount = 0; eErrCount = 0;
        end else begin
            errKind   = 0;
            eTxnValid = 0;
            if (!enable) begin
                phase = 0;
            end else if (phase == 0) begin
                if (start) begin mAddr[15:8] = address; phase = 1; end
                else if (dataValid) errKind = 1;
            end else if (phase == 1) begin
                if (start) begin
                    errKind = 2; mAddr[15:8] = address;
                end else begin
                    mAddr[7:0] = address; mRead = read; mWaits = 0; phase = 2;
                    if (dataValid) errKind = 1;
                end
            end else begin
                if (dataValid) begin
                    eTxnValid = 1; eTxnRead = mRead; eTxnAddr = mAddr; eTxnData = data;
                    eTxnWait = (mWaits > 255) ? 8'd255 : 8'(mWaits);
                    phase = 0;
                end
                if (start) begin
                    if (!dataValid) errKind = 2;
                    mAddr[15:8] = address; phase = 1;
                end else if (!dataValid) begin
                    mWaits++;
                    if (mWaits == TMO) begin errKind = 3; phase = 0; end
                end
            end
            eErrValid = (errKind != 0);
            if (errKind != 0) eErrCode = 2'(errKind);
            if (clrCounts) begin
                eTxnCount = 0; eErrCount = 0;
            end else begin
                if (eTxnValid) eTxnCount = eTxnCount + 16'd1;
                if (eErrValid && eErrCount < 255) eErrCount++;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        chk("outputs",
            {3'b0, txnValid, txnRead, txnAddr, txnData, txnWait, errValid, errCode, txnCount, errCount},
            {3'b0, eTxnValid, eTxnRead, eTxnAddr, eTxnData, eTxnWait, eErrValid, eErrCode, eTxnCount, 8'(eErrCount)});
    end

    task automatic drive(input logic s, input logic r, input logic dv,
                         input logic [7:0] a, input logic [7:0] d);
        start = s; read = r; dataValid = dv; address = a; data = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetN = 1'b0; enable = 1'b1; clrCounts = 1'b0;
        start = 0; read = 0; dataValid = 0; address = 0; data = 0;
        @(posedge clock); @(posedge clock); #1;
        chk("reset_txnCount", 64'(txnCount), 64'h0);
        chk("reset_txnAddr", 64'(txnAddr), 64'h0);
        chk("reset_errCode", 64'(errCode), 64'h0);
        resetN = 1'b1;

        // Read, data in first wait cycle
        drive(1, 0, 0, 8'h12, 8'h00);
        drive(0, 1, 0, 8'h34, 8'h00);
        drive(0, 0, 1, 8'h00, 8'h34);
        chk("rd_valid", 64'(txnValid), 64'h1);
        chk("rd_read", 64'(txnRead), 64'h1);
        chk("rd_addr", 64'(txnAddr), 64'h1234);
        chk("rd_data", 64'(txnData), 64'h34);
        chk("rd_wait", 64'(txnWait), 64'h0);
        chk("rd_count", 64'(txnCount), 64'h1);
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("hold_pulse", 64'(txnValid), 64'h0);
        chk("hold_addr", 64'(txnAddr), 64'h1234);

        // Write with 3 wait cycles
        drive(1, 0, 0, 8'hAB, 8'h00);
        drive(0, 0, 0, 8'hCD, 8'h00);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 1, 8'h00, 8'h5A);
        chk("wr_read", 64'(txnRead), 64'h0);
        chk("wr_addr", 64'(txnAddr), 64'hABCD);
        chk("wr_data", 64'(txnData), 64'h5A);
        chk("wr_wait", 64'(txnWait), 64'h3);

        // Timeout after 16 idle wait cycles
        drive(1, 0, 0, 8'h11, 8'h00);
        drive(0, 1, 0, 8'h22, 8'h00);
        for (int i = 0; i < TMO - 1; i++) drive(0, 0, 0, 8'h00, 8'h00);
        chk("tmo_early", 64'(errValid), 64'h0);
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("tmo_valid", 64'(errValid), 64'h1);
        chk("tmo_code", 64'(errCode), 64'h3);
        chk("tmo_errCount", 64'(errCount), 64'h1);
        chk("tmo_txnCount", 64'(txnCount), 64'h2);

        // Spurious dataValid in IDLE (proves FSM returned to IDLE)
        drive(0, 0, 1, 8'h00, 8'hEE);
        chk("spur_code", 64'(errCode), 64'h1);

        // Start during RD_WAIT, new transaction completes
        drive(1, 0, 0, 8'h55, 8'h00);
        drive(0, 1, 0, 8'h66, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(1, 0, 0, 8'h77, 8'h00);
        chk("restart_code", 64'(errCode), 64'h2);
        chk("restart_noTxn", 64'(txnValid), 64'h0);
        drive(0, 0, 0, 8'h88, 8'h00);
        drive(0, 0, 1, 8'h00, 8'h99);
        chk("restart_addr", 64'(txnAddr), 64'h7788);
        chk("restart_data", 64'(txnData), 64'h99);

        // Back-to-back: data and start together
        drive(1, 0, 0, 8'h01, 8'h00);
        drive(0, 1, 0, 8'h02, 8'h00);
        drive(1, 0, 1, 8'h03, 8'hAA);
        chk("b2b_valid", 64'(txnValid), 64'h1);
        chk("b2b_noErr", 64'(errValid), 64'h0);
        chk("b2b_addr1", 64'(txnAddr), 64'h0102);
        drive(0, 0, 0, 8'h04, 8'h00);
        drive(0, 0, 1, 8'h00, 8'hBB);
        chk("b2b_addr2", 64'(txnAddr), 64'h0304);
        chk("b2b_count", 64'(txnCount), 64'h5);

        // ADDR_LO with start and dataValid: only the start error
        drive(1, 0, 0, 8'h10, 8'h00);
        drive(1, 0, 1, 8'h20, 8'h00);
        chk("prio_code", 64'(errCode), 64'h2);
        drive(0, 1, 0, 8'h30, 8'h00);
        drive(0, 0, 1, 8'h00, 8'h01);
        chk("prio_addr", 64'(txnAddr), 64'h2030);
        chk("prio_errCount", 64'(errCount), 64'h4);

        // enable=0 mid-transaction discards it silently
        drive(1, 0, 0, 8'h40, 8'h00);
        drive(0, 0, 0, 8'h50, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        enable = 1'b0;
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 1, 8'h00, 8'h00);
        chk("dis_noErr", 64'(errValid), 64'h0);
        chk("dis_hold", 64'(txnAddr), 64'h2030);
        enable = 1'b1;
        drive(0, 0, 1, 8'h00, 8'h77);
        chk("dis_idle_code", 64'(errCode), 64'h1);
        chk("dis_txnCount", 64'(txnCount), 64'h6);
        chk("dis_errCount", 64'(errCount), 64'h5);

        // Asynchronous reset during WR_WAIT
        drive(1, 0, 0, 8'hA0, 8'h00);
        drive(0, 0, 0, 8'hA1, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        resetN = 1'b0;
        #1;
        chk("arst_txnCount", 64'(txnCount), 64'h0);
        chk("arst_txnAddr", 64'(txnAddr), 64'h0);
        chk("arst_errCount", 64'(errCount), 64'h0);
        @(posedge clock); #1;
        resetN = 1'b1;
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);
        chk("arst_noTxn", 64'(txnValid), 64'h0);
        chk("arst_noErr", 64'(errValid), 64'h0);

        // errCount saturation
        for (int i = 0; i < 255; i++) drive(0, 0, 1, 8'h00, 8'h00);
        chk("sat_255", 64'(errCount), 64'hFF);
        drive(0, 0, 1, 8'h00, 8'h00);
        chk("sat_pulse", 64'(errValid), 64'h1);
        chk("sat_hold", 64'(errCount), 64'hFF);

        // clrCounts coinciding with a completed transaction
        drive(1, 0, 0, 8'hC0, 8'h00);
        drive(0, 1, 0, 8'hC1, 8'h00);
        clrCounts = 1'b1;
        drive(0, 0, 1, 8'h00, 8'h3C);
        clrCounts = 1'b0;
        chk("clr_valid", 64'(txnValid), 64'h1);
        chk("clr_txnCount", 64'(txnCount), 64'h0);
        chk("clr_errCount", 64'(errCount), 64'h0);
        drive(0, 0, 0, 8'h00, 8'h00);
        drive(0, 0, 0, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
